// File: rtl/pdu_lqlist_builder_pkg.sv
// Shared PDU constants: LQ count, index width and builder FSM encoding.
// Every PDU block imports these so list widths agree across the unit.
package pdu_lqlist_builder_pkg;

  localparam int NUM_LQ    = 16;
  localparam int LQADDR_BW = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/pdu_lqlist_builder_if.sv
// Index-in / list-out valid/ready bundle of the LQ list builder.
// master drives beats and takes lists; slave is the builder side.
interface pdu_lqlist_builder_if #(
  parameter int NUM_LQ    = pdu_lqlist_builder_pkg::NUM_LQ,
  parameter int LQADDR_BW = pdu_lqlist_builder_pkg::LQADDR_BW
);

  logic                 in_valid;
  logic                 in_ready;
  logic [LQADDR_BW-1:0] in_lqidx;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_LQ-1:0]    out_lqlist;
  logic [LQADDR_BW:0]   out_cnt;

  modport master (
    output in_valid, in_lqidx, in_last, out_ready,
    input  in_ready, out_valid, out_lqlist, out_cnt
  );

  modport slave (
    input  in_valid, in_lqidx, in_last, out_ready,
    output in_ready, out_valid, out_lqlist, out_cnt
  );

endinterface

// File: rtl/pdu_lqlist_builder_lqbit_setter.sv
// Sets one index bit in the LQ accumulator; flags new bits and range.
// Out-of-range indices leave the accumulator untouched.
module pdu_lqbit_setter #(
  parameter int NUM_LQ    = 16,
  parameter int LQADDR_BW = 4
) (
  input  logic [NUM_LQ-1:0]    acc,
  input  logic [LQADDR_BW-1:0] idx,
  output logic [NUM_LQ-1:0]    acc_nxt,
  output logic                 newly_set,
  output logic                 in_range
);

  logic [NUM_LQ-1:0] mask;

  always_comb begin
    in_range  = (32'(idx) < NUM_LQ);
    mask      = '0;
    if (in_range)
      mask = NUM_LQ'(1) << idx;
    newly_set = |(mask & ~acc);
    acc_nxt   = acc | mask;
  end

endmodule

// File: rtl/pdu_lqlist_builder.sv
// Packs a serial LQ index stream into a one-hot LQ list with popcount.
// Define PDU_LQB_DUPCHK_EN to add err_dup / out_dup duplicate reporting.
module pdu_lqlist_builder #(
  parameter int NUM_LQ    = pdu_lqlist_builder_pkg::NUM_LQ,
  parameter int LQADDR_BW = pdu_lqlist_builder_pkg::LQADDR_BW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  pdu_lqlist_builder_if.slave bus,
`ifdef PDU_LQB_DUPCHK_EN
  output logic                err_dup,
  output logic                out_dup,
`endif
  output logic                err_range
);

  import pdu_lqlist_builder_pkg::*;

  state_t               state;
  state_t               state_nxt;
  logic [NUM_LQ-1:0]    acc;
  logic [NUM_LQ-1:0]    acc_set;
  logic [LQADDR_BW:0]   cnt;
  logic                 newly;
  logic                 in_range;
  logic                 accept;
  logic                 take;

  pdu_lqbit_setter #(
    .NUM_LQ    (NUM_LQ),
    .LQADDR_BW (LQADDR_BW)
  ) u_setter (
    .acc       (acc),
    .idx       (bus.in_lqidx),
    .acc_nxt   (acc_set),
    .newly_set (newly),
    .in_range  (in_range)
  );

  // flush wins over both handshakes, so a beat seen with flush is lost
  assign bus.in_ready   = (state == COLLECT);
  assign bus.out_valid  = (state == HOLD);
  assign accept         = bus.in_valid & bus.in_ready & ~flush;
  assign take           = bus.out_valid & bus.out_ready & ~flush;
  assign bus.out_lqlist = bus.out_valid ? acc : '0;
  assign bus.out_cnt    = bus.out_valid ? cnt : '0;

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      flush:                 state_nxt = COLLECT;
      take:                  state_nxt = COLLECT;
      accept & bus.in_last:  state_nxt = HOLD;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= COLLECT;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || flush || take) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_set;
      cnt <= cnt + (LQADDR_BW+1)'(newly);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_range <= 1'b0;
    else
      err_range <= accept & ~in_range;
  end

`ifdef PDU_LQB_DUPCHK_EN
  logic dup_seen;

  assign out_dup = bus.out_valid & dup_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_dup  <= 1'b0;
      dup_seen <= 1'b0;
    end else begin
      err_dup <= accept & in_range & ~newly;
      if (flush || take)
        dup_seen <= 1'b0;
      else if (accept && in_range && !newly)
        dup_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pdu_lqlist_builder.sv
// Scoreboard bench for pdu_lqlist_builder (16-LQ and 12-LQ instances).
// Expected lists are queued at stimulus time and popped on handshake.
module tb_pdu_lqlist_builder;

  typedef struct packed {
    logic [15:0] l;
    logic [4:0]  c;
    logic        d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic flush_b;
  logic err_range;
  logic err_range_b;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  always #5 clk = ~clk;

  pdu_lqlist_builder_if #(.NUM_LQ(16), .LQADDR_BW(4)) bus ();
  pdu_lqlist_builder_if #(.NUM_LQ(12), .LQADDR_BW(4)) busb ();

`ifdef PDU_LQB_DUPCHK_EN
  logic err_dup, out_dup, err_dup_b, out_dup_b;
  int   dup_pulses = 0;
  always @(negedge clk) if (err_dup) dup_pulses++;
`endif

  pdu_lqlist_builder #(.NUM_LQ(16), .LQADDR_BW(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
`ifdef PDU_LQB_DUPCHK_EN
    .err_dup   (err_dup),
    .out_dup   (out_dup),
`endif
    .err_range (err_range)
  );

  pdu_lqlist_builder #(.NUM_LQ(12), .LQADDR_BW(4)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush_b),
    .bus       (busb),
`ifdef PDU_LQB_DUPCHK_EN
    .err_dup   (err_dup_b),
    .out_dup   (out_dup_b),
`endif
    .err_range (err_range_b)
  );

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] x);
    n_vec++;
    if (a !== x) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, x);
    end
  endtask

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_list actual=%0h required=none",
                 bus.out_lqlist);
      end else begin
        ea = q.pop_front();
        chk("out_lqlist", 32'(bus.out_lqlist), 32'(ea.l));
        chk("out_cnt", 32'(bus.out_cnt), 32'(ea.c));
`ifdef PDU_LQB_DUPCHK_EN
        chk("out_dup", 32'(out_dup), 32'(ea.d));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (busb.out_valid && busb.out_ready) begin
      if (qb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_list_b actual=%0h required=none",
                 busb.out_lqlist);
      end else begin
        eb = qb.pop_front();
        chk("b_out_lqlist", 32'(busb.out_lqlist), 32'(eb.l));
        chk("b_out_cnt", 32'(busb.out_cnt), 32'(eb.c));
      end
    end
  end

  task automatic send(input logic [3:0] idx, input logic last);
    bus.in_valid = 1'b1;
    bus.in_lqidx = idx;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PDU_LQB_DUPCHK_EN
    int d0;
`endif
    rst = 1'b1;
    flush = 1'b0;
    flush_b = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_lqidx = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    busb.in_valid = 1'b0;
    busb.in_lqidx = '0;
    busb.in_last = 1'b0;
    busb.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_lqlist", 32'(bus.out_lqlist), 0);
    chk("rst_out_cnt", 32'(bus.out_cnt), 0);
    chk("rst_err_range", 32'(err_range), 0);

    // basic list 3,7,12
    bus.out_ready = 1'b1;
    q.push_back('{l: 16'h1088, c: 5'd3, d: 1'b0});
    send(4'd3, 1'b0);
    send(4'd7, 1'b0);
    send(4'd12, 1'b1);
    chk("basic_latency_valid", 32'(bus.out_valid), 1);
    chk("basic_hold_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    chk("basic_in_ready_back", 32'(bus.in_ready), 1);
    chk("basic_valid_drop", 32'(bus.out_valid), 0);

    // duplicates with backpressure
    bus.out_ready = 1'b0;
    q.push_back('{l: 16'h0021, c: 5'd2, d: 1'b1});
`ifdef PDU_LQB_DUPCHK_EN
    d0 = dup_pulses;
`endif
    send(4'd5, 1'b0);
    send(4'd5, 1'b0);
    send(4'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_lqlist", 32'(bus.out_lqlist), 32'h0021);
      chk("bp_cnt", 32'(bus.out_cnt), 2);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_drop", 32'(bus.out_valid), 0);
`ifdef PDU_LQB_DUPCHK_EN
    chk("dup_pulse_count", 32'(dup_pulses - d0), 1);
`endif

    // full list 0..15 plus repeat of 15
    q.push_back('{l: 16'hFFFF, c: 5'd16, d: 1'b1});
    for (int i = 0; i < 16; i++) send(4'(i), 1'b0);
    send(4'd15, 1'b1);
    chk("full_err_range", 32'(err_range), 0);
    @(posedge clk);
    #1;

    // NUM_LQ=12 instance: lone out-of-range beat
    qb.push_back('{l: 16'h0000, c: 5'd0, d: 1'b0});
    busb.out_ready = 1'b1;
    busb.in_valid = 1'b1;
    busb.in_lqidx = 4'd13;
    busb.in_last = 1'b1;
    @(posedge clk);
    #1;
    busb.in_valid = 1'b0;
    busb.in_last = 1'b0;
    chk("b_err_range_pulse", 32'(err_range_b), 1);
    chk("b_out_valid", 32'(busb.out_valid), 1);
    @(posedge clk);
    #1;
    chk("b_err_range_clear", 32'(err_range_b), 0);
    chk("b_in_ready", 32'(busb.in_ready), 1);

    // flush mid-list drops partial list and the flush-cycle beat
    q.push_back('{l: 16'h0002, c: 5'd1, d: 1'b0});
    send(4'd2, 1'b0);
    send(4'd4, 1'b0);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_lqidx = 4'd9;
    bus.in_last = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    chk("flush_mid_valid", 32'(bus.out_valid), 0);
    chk("flush_mid_err_range", 32'(err_range), 0);
    send(4'd1, 1'b1);
    @(posedge clk);
    #1;

    // flush while holding
    bus.out_ready = 1'b0;
    send(4'd4, 1'b1);
    chk("hold_valid", 32'(bus.out_valid), 1);
    chk("hold_lqlist", 32'(bus.out_lqlist), 32'h0010);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("hflush_valid", 32'(bus.out_valid), 0);
    chk("hflush_lqlist", 32'(bus.out_lqlist), 0);
    chk("hflush_cnt", 32'(bus.out_cnt), 0);
    chk("hflush_in_ready", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset while holding
    bus.out_ready = 1'b0;
    send(4'd4, 1'b1);
    chk("hold2_valid", 32'(bus.out_valid), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("hrst_valid", 32'(bus.out_valid), 0);
    chk("hrst_lqlist", 32'(bus.out_lqlist), 0);
    chk("hrst_cnt", 32'(bus.out_cnt), 0);
    chk("hrst_in_ready", 32'(bus.in_ready), 1);
    chk("hrst_err_range", 32'(err_range), 0);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    chk("queue_drained", 32'(q.size()), 0);
    chk("queue_b_drained", 32'(qb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pdu_lqlist_builder.md
Name: pdu_lqlist_builder

Overview:
- Inverse of the PDU LQ indexer: accepts a serial stream of logical-qubit indices and packs them into a one-hot-per-qubit LQ list bitmask.
- A beat flagged `in_last` closes the list. The list is then presented on a valid/ready output port for the downstream indexer/dispatcher.
- Sits between the instruction decode front-end and the LQ list registers of the PDU.

Parameters:
- NUM_LQ, 16, number of logical qubits; width of the LQ list.
- LQADDR_BW, 4, index width; must satisfy 2^LQADDR_BW >= NUM_LQ.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  index beat valid.
- in_ready  output  1  builder can accept a beat.
- in_lqidx  input  LQADDR_BW  logical-qubit index of the beat.
- in_last  input  1  beat is the final index of the current list.
- flush  input  1  abort: discard any partial or held list.
- out_valid  output  1  completed list available.
- out_ready  input  1  consumer takes the list.
- out_lqlist  output  NUM_LQ  completed LQ list; bit i = qubit i present.
- out_cnt  output  LQADDR_BW+1  number of distinct qubits in out_lqlist.
- err_range  output  1  one-cycle pulse: an accepted beat had in_lqidx >= NUM_LQ.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=COLLECT; accumulator=0; count=0.
  - out_valid=0, out_lqlist=0, out_cnt=0, err_range=0.
  - in_ready=1 from the first cycle after reset.
- State COLLECT:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready.
  - On accept with in_lqidx < NUM_LQ: acc[in_lqidx] is set. count increments only if that bit was previously 0, so duplicates are absorbed and count = popcount(acc).
  - On accept with in_lqidx >= NUM_LQ: acc and count are unchanged; err_range=1 in the next cycle (registered pulse). in_last on such a beat still closes the list.
  - On accept with in_last=1: next state=HOLD. out_lqlist and out_cnt load the final accumulator value, including the current beat.
  - Latency: last beat accepted at edge N -> out_valid=1 after edge N.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_lqlist and out_cnt are stable until the handshake completes.
  - Handshake out_valid & out_ready at edge M:
    - state returns to COLLECT; acc and count are cleared.
    - out_lqlist and out_cnt clear to 0; out_valid=0 after edge M.
    - in_ready=1 after edge M. There is no same-cycle bypass, so minimum spacing between lists is one bubble cycle.
- Empty list: not representable; every list holds at least one beat.
  - A lone out-of-range beat with in_last gives out_lqlist=0 and out_cnt=0, and is still presented.
- Full list: all NUM_LQ bits set gives out_cnt=NUM_LQ. out_cnt width covers NUM_LQ exactly.
- Flush:
  - Highest priority below rst, in any state.
  - Clears acc and count, state=COLLECT, out_valid=0, out_lqlist=0, out_cnt=0.
  - A beat presented in the same cycle is dropped, even though in_ready may read 1.
  - err_range is not asserted for a dropped beat.
- Reset mid-list behaves identically to flush.
- Simultaneous events:
  - rst > flush > output handshake > input accept.
  - In HOLD, input is never accepted (in_ready=0).
- in_ready depends only on registered state, not combinationally on out_ready.

Optional Feature:
- Macro: PDU_LQB_DUPCHK_EN.
- Defined:
  - Adds output `err_dup` (1 bit). It is a registered one-cycle pulse when an accepted in-range beat targets a bit already set in acc.
  - Also adds HOLD-stable output `out_dup`, set if any duplicate occurred in the presented list. out_dup clears on handshake, flush and rst.
- Undefined: neither port exists; duplicates are silently merged as above.

Decomposition:
- Shared define header: NUM_LQ, LQADDR_BW and the state encoding constants (COLLECT=1'b0, HOLD=1'b1).
- All PDU blocks use these same constants.
- One natural sub-module: pdu_lqbit_setter (combinational). Inputs: acc and idx. Outputs: next acc, a "newly set" flag and an "in range" flag.
- The FSM, counter and registers stay in the top.

Test Plan:
- Basic list: after reset, beats 3, 7, 12 (last) back-to-back with out_ready=1 -> out_valid one cycle after beat 12, out_lqlist=0x1088, out_cnt=3. in_ready returns to 1 the cycle after the handshake.
- Duplicates and backpressure: beats 5, 5, 0 (last) with out_ready=0 for 4 cycles.
  - out_lqlist=0x0021 and out_cnt=2, stable for all 4 cycles; in_ready=0 throughout.
  - With PDU_LQB_DUPCHK_EN: err_dup pulses once, out_dup=1.
- Full and range: beats 0..15 then a beat of 15 with last -> out_lqlist=0xFFFF, out_cnt=16.
  - Separate run with NUM_LQ=12: beat 13 (last) -> err_range pulses, out_lqlist=0, out_cnt=0.
- Flush mid-list: beats 2, 4, then flush asserted together with beat 9 (last), then beat 1 (last) -> single output out_lqlist=0x0002, out_cnt=1. Beat 9 never appears.
- Flush in HOLD and reset mid-operation:
  - Hold list 0x0010, assert flush -> out_valid=0 next cycle; the list is never delivered.
  - Repeat with rst instead of flush -> all outputs 0, in_ready=1 after reset.
